// File: rtl/tdm_pkg.sv
// Shared types and constants for the 4-slot TDM receive path.
package tdm_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    SYNC = 1'b1
  } state_e;

  localparam int unsigned TDM_SLOTS = 4;
  localparam int unsigned SLOT_W    = 2;

endpackage

// File: rtl/tdm_demux4_if.sv
// Serial-in / parallel-out signal bundle of the TDM demultiplexer.
interface tdm_demux4_if;

  logic                       en;
  logic                       din;
  logic                       fsync;
  logic [3:0]                 y;
  logic                       frame_valid;
  logic [tdm_pkg::SLOT_W-1:0] slot;
  logic                       locked;
  logic                       sync_err;

  // master: serial link source; slave: the demultiplexer
  modport master (
    output en, din, fsync,
    input  y, frame_valid, slot, locked, sync_err
  );

  modport slave (
    input  en, din, fsync,
    output y, frame_valid, slot, locked, sync_err
  );

endinterface

// File: rtl/tdm_slot_ctr.sv
// Slot position counter: clear to 0, load to 1, or advance with wrap after slot 3.
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              load1_i,
  input  logic              inc_i,
  output logic [SLOT_W-1:0] slot_o
);

  logic [SLOT_W-1:0] slot_q, slot_d;

  always_comb begin
    slot_d = slot_q;
    if (clr_i) begin
      slot_d = '0;
    end else if (load1_i) begin
      slot_d = SLOT_W'(1);
    end else if (inc_i) begin
      slot_d = (slot_q == SLOT_W'(TDM_SLOTS - 1)) ? '0 : slot_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot_o = slot_q;

endmodule

// File: rtl/tdm_demux4.sv
// 4-slot TDM demultiplexer: locks to fsync, collects four enabled bits per frame,
// and presents each completed frame in parallel with a one-cycle valid strobe.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int unsigned MAX_MISS = 2
) (
  input logic         clk,
  input logic         rst_n,
  tdm_demux4_if.slave bus
);

  localparam logic [2:0] MISS_LIM = 3'(MAX_MISS);

  state_e            state_q, state_d;
  logic [2:0]        shadow_q, shadow_d;
  logic [3:0]        y_q, y_d;
  logic              fv_q, fv_d;
  logic              err_q, err_d;
  logic [2:0]        miss_q, miss_d;
  logic [2:0]        miss_inc;
  logic [SLOT_W-1:0] slot;
  logic              ctr_clr, ctr_load1, ctr_inc;

  tdm_slot_ctr u_slot_ctr (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clr_i   (ctr_clr),
    .load1_i (ctr_load1),
    .inc_i   (ctr_inc),
    .slot_o  (slot)
  );

  assign miss_inc = miss_q + 3'd1;

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    y_d       = y_q;
    fv_d      = 1'b0;
    err_d     = 1'b0;
    miss_d    = miss_q;
    ctr_clr   = 1'b0;
    ctr_load1 = 1'b0;
    ctr_inc   = 1'b0;

    if (bus.en) begin
      if (bus.fsync) begin
        // fsync always restarts the frame at slot 0; it is a violation unless expected there
        err_d       = (state_q == SYNC) && (slot != '0);
        shadow_d[0] = bus.din;
        ctr_load1   = 1'b1;
        miss_d      = '0;
        state_d     = SYNC;
      end else if (state_q == SYNC) begin
        unique case (slot)
          2'd0: begin
            err_d = 1'b1;
            if (miss_inc >= MISS_LIM) begin
              state_d = HUNT;
              ctr_clr = 1'b1;
              miss_d  = '0;
            end else begin
              miss_d      = miss_inc;
              shadow_d[0] = bus.din;
              ctr_load1   = 1'b1;
            end
          end
          2'd1: begin
            shadow_d[1] = bus.din;
            ctr_inc     = 1'b1;
          end
          2'd2: begin
            shadow_d[2] = bus.din;
            ctr_inc     = 1'b1;
          end
          default: begin
            y_d     = {bus.din, shadow_q};
            fv_d    = 1'b1;
            ctr_inc = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HUNT;
      shadow_q <= '0;
      y_q      <= '0;
      fv_q     <= 1'b0;
      err_q    <= 1'b0;
      miss_q   <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      y_q      <= y_d;
      fv_q     <= fv_d;
      err_q    <= err_d;
      miss_q   <= miss_d;
    end
  end

  assign bus.y           = y_q;
  assign bus.frame_valid = fv_q;
  assign bus.slot        = slot;
  assign bus.locked      = (state_q == SYNC);
  assign bus.sync_err    = err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed, table-driven bench for tdm_demux4 with MAX_MISS=2.
module tb_tdm_demux4;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  tdm_demux4_if bus ();

  tdm_demux4 #(.MAX_MISS(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       en;
    logic       din;
    logic       fs;
    logic [3:0] y;
    logic       fv;
    logic [1:0] slot;
    logic       lk;
    logic       err;
  } vec_t;

  localparam int NVEC = 37;
  vec_t vt [NVEC];

  task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] y, input logic fv,
                     input logic [1:0] sl, input logic lk, input logic err);
    cmp({tag, ".y"}, bus.y, y);
    cmp({tag, ".frame_valid"}, {3'b0, bus.frame_valid}, {3'b0, fv});
    cmp({tag, ".slot"}, {2'b0, bus.slot}, {2'b0, sl});
    cmp({tag, ".locked"}, {3'b0, bus.locked}, {3'b0, lk});
    cmp({tag, ".sync_err"}, {3'b0, bus.sync_err}, {3'b0, err});
  endtask

  task automatic step(input logic en, input logic din, input logic fs);
    bus.en    = en;
    bus.din   = din;
    bus.fsync = fs;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic en, input logic din, input logic fs,
                              input logic [3:0] y, input logic fv, input logic [1:0] sl,
                              input logic lk, input logic err);
    mk = {en, din, fs, y, fv, sl, lk, err};
  endfunction

  initial begin
    logic [3:0] ey;
    logic       efv;
    checks   = 0;
    failures = 0;

    // en din fs | y fv slot locked err
    vt[0]  = mk(1,1,0, 4'h0,0,0,0,0);  // HUNT discards bit without fsync
    vt[1]  = mk(1,1,1, 4'h0,0,1,1,0);  // frame 1,0,1,1
    vt[2]  = mk(1,0,0, 4'h0,0,2,1,0);
    vt[3]  = mk(1,1,0, 4'h0,0,3,1,0);
    vt[4]  = mk(1,1,0, 4'hD,1,0,1,0);
    vt[5]  = mk(1,0,1, 4'hD,0,1,1,0);  // frame 4'hA
    vt[6]  = mk(1,1,0, 4'hD,0,2,1,0);
    vt[7]  = mk(1,0,0, 4'hD,0,3,1,0);
    vt[8]  = mk(1,1,0, 4'hA,1,0,1,0);
    vt[9]  = mk(1,1,1, 4'hA,0,1,1,0);  // frame 4'h5
    vt[10] = mk(1,0,0, 4'hA,0,2,1,0);
    vt[11] = mk(1,1,0, 4'hA,0,3,1,0);
    vt[12] = mk(1,0,0, 4'h5,1,0,1,0);
    vt[13] = mk(1,0,1, 4'h5,0,1,1,0);  // broken frame
    vt[14] = mk(1,0,0, 4'h5,0,2,1,0);
    vt[15] = mk(1,1,1, 4'h5,0,1,1,1);  // fsync at slot 2 -> resync
    vt[16] = mk(1,1,0, 4'h5,0,2,1,0);
    vt[17] = mk(1,1,0, 4'h5,0,3,1,0);
    vt[18] = mk(1,0,0, 4'h7,1,0,1,0);
    vt[19] = mk(1,1,0, 4'h7,0,1,1,1);  // first missing fsync, flywheel
    vt[20] = mk(1,0,0, 4'h7,0,2,1,0);
    vt[21] = mk(1,0,0, 4'h7,0,3,1,0);
    vt[22] = mk(1,1,0, 4'h9,1,0,1,0);
    vt[23] = mk(1,1,0, 4'h9,0,0,0,1);  // second miss -> HUNT
    vt[24] = mk(1,1,0, 4'h9,0,0,0,0);
    vt[25] = mk(0,1,1, 4'h9,0,0,0,0);  // en=0 ignores fsync
    vt[26] = mk(1,1,1, 4'h9,0,1,1,0);
    vt[27] = mk(1,1,0, 4'h9,0,2,1,0);
    vt[28] = mk(1,1,0, 4'h9,0,3,1,0);
    vt[29] = mk(1,1,0, 4'hF,1,0,1,0);
    vt[30] = mk(1,0,1, 4'hF,0,1,1,0);
    vt[31] = mk(1,0,0, 4'hF,0,2,1,0);
    vt[32] = mk(1,0,0, 4'hF,0,3,1,0);
    vt[33] = mk(1,1,1, 4'hF,0,1,1,1);  // fsync at slot 3: no frame out
    vt[34] = mk(1,0,0, 4'hF,0,2,1,0);
    vt[35] = mk(1,0,0, 4'hF,0,3,1,0);
    vt[36] = mk(1,0,0, 4'h1,1,0,1,0);

    rst_n     = 1'b0;
    bus.en    = 1'b0;
    bus.din   = 1'b0;
    bus.fsync = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", 4'h0, 0, 2'd0, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      step(vt[i].en, vt[i].din, vt[i].fs);
      chk($sformatf("vec%0d", i), vt[i].y, vt[i].fv, vt[i].slot, vt[i].lk, vt[i].err);
    end

    // Stalled frame 1,0,1,1 with en alternating: completes on the 7th edge only.
    for (int c = 0; c < 8; c++) begin
      logic [3:0] bits;
      bits = 4'b1101;
      if (c % 2 == 0) step(1'b1, bits[c/2], (c == 0));
      else            step(1'b0, 1'b1, 1'b1);
      ey  = (c >= 6) ? 4'hD : 4'h1;
      efv = (c == 6);
      cmp($sformatf("stall%0d.y", c), bus.y, ey);
      cmp($sformatf("stall%0d.frame_valid", c), {3'b0, bus.frame_valid}, {3'b0, efv});
      cmp($sformatf("stall%0d.sync_err", c), {3'b0, bus.sync_err}, 4'h0);
    end

    // Asynchronous reset in mid-frame, then bits without fsync are ignored.
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    chk("pre_rst", 4'hD, 0, 2'd2, 1, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_rst", 4'h0, 0, 2'd0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step(1'b1, c[0], 1'b0);
      chk($sformatf("post_rst%0d", c), 4'h0, 0, 2'd0, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Time-division demultiplexer that recovers four 1-bit channels from a serial stream produced by the 4:1 select-driven multiplexer, i.e. the receive end of the same 4-slot TDM link. A frame is four consecutive enabled bits, slot 0 marked by `fsync`. The block locks to `fsync`, steers each bit to its channel slot, and presents the completed 4-bit frame in parallel with a one-cycle valid strobe. It sits between the serial link input and the per-channel consumers.

## Interface
- `MAX_MISS`, default 2: consecutive slot-0 positions without `fsync` tolerated before lock is dropped; legal range 1..7.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `en` in 1: sample enable; a bit is consumed only on cycles with `en`=1.
- `din` in 1: serial data bit.
- `fsync` in 1: frame sync, qualified by `en`; marks `din` as slot 0.
- `y` out 4: last complete frame; `y[k]` = slot-k bit.
- `frame_valid` out 1: one-cycle pulse when `y` is updated.
- `slot` out 2: slot index expected for the next enabled bit.
- `locked` out 1: 1 while in SYNC.
- `sync_err` out 1: one-cycle pulse on any sync violation.

## Operation
- States: HUNT, SYNC. Reset state HUNT.
- Reset values: `y`=4'b0000, `frame_valid`=0, `slot`=2'b00, `locked`=0, `sync_err`=0, internal shadow=0, miss count=0.
- `en`=0: no state, slot, shadow or `y` change; `frame_valid`, `sync_err` are 0 that cycle.
- HUNT, enabled, `fsync`=0: bit discarded, stay.
- HUNT, enabled, `fsync`=1: shadow[0]<=`din`, `slot`<=1, miss<=0, go SYNC.
- SYNC, enabled, `slot`=1 or 2: shadow[`slot`]<=`din`, `slot`++. If `fsync`=1: `sync_err` pulse, discard partial frame, treat bit as slot 0 (shadow[0]<=`din`, `slot`<=1), stay SYNC, miss<=0.
- SYNC, enabled, `slot`=3, `fsync`=0: `y`<={`din`, shadow[2:0]}, `frame_valid` pulse, `slot`<=0 (wrap). `fsync`=1 here: resync as above, no frame output.
- SYNC, enabled, `slot`=0, `fsync`=1: shadow[0]<=`din`, `slot`<=1, miss<=0.
- SYNC, enabled, `slot`=0, `fsync`=0 (flywheel): miss++, `sync_err` pulse. If new miss < `MAX_MISS`: accept bit as slot 0, `slot`<=1. If new miss = `MAX_MISS`: bit discarded, go HUNT, `slot`<=0, miss<=0.
- Miss counter is 3 bits, saturates never (cleared before exceeding `MAX_MISS`).
- Shadow slots not yet written in a frame are never exposed: `y` changes only on a slot-3 completion.

## Timing
- All outputs registered; update on the rising `clk` edge that samples the bit.
- Latency: slot-3 bit sampled at edge N -> `y` and `frame_valid` visible after edge N, pulse low after edge N+1 unless another frame completes.
- Back-to-back frames at `en`=1 continuous: `frame_valid` every 4th cycle.
- `locked` rises the cycle after the HUNT `fsync` edge; falls after the edge that hits `MAX_MISS`.
- `rst_n` asserted mid-frame: all outputs to reset values immediately (asynchronous), partial frame lost; first post-reset frame requires a fresh `fsync`.

## Structure
- Shared package `tdm_pkg`: state enum {HUNT, SYNC}, `TDM_SLOTS`=4, `SLOT_W`=2.
- One natural sub-module: `tdm_slot_ctr` (enable, load-to-1, wrap-at-3 slot counter); FSM, shadow and miss logic in the top.

## Test plan
- Reset then `en`=1, `fsync` on bit 0, bits 1,0,1,1 -> after 4th edge `y`=4'b1101, `frame_valid` one cycle, `locked`=1.
- Continuous frames 4'hA, 4'h5 with `fsync` every 4th bit -> `frame_valid` every 4 cycles, `y`=4'hA then 4'h5, `sync_err` never.
- `en` toggling 1/0 every cycle within a frame -> same `y` as unstalled, completion delayed to 8th cycle, no extra pulses.
- `fsync` at `slot`=2 -> `sync_err` pulse, no `frame_valid` for the broken frame, next frame from that bit decodes correctly.
- `MAX_MISS`=2, remove `fsync` after lock -> first missing slot 0: `sync_err`, frame still output; second: `sync_err`, `locked`=0, HUNT.
- `rst_n` low at `slot`=2 -> outputs zero asynchronously; subsequent bits without `fsync` ignored.
